// File: rtl/switch_pkg.sv
// Shared constants for the slide-switch conditioning path feeding the switch PIO.
// Also holds the counter-width helper used by every per-bit filter.
package switch_pkg;

    localparam int SW_WIDTH                   = 10;
    localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int SW_DEBOUNCE_CYCLES_SIM     = 4;

    // Smallest counter able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int sw_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, debounced level
// and registered rise/fall strobes.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int              CNT_W   = sw_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic s1;
    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic s2;

    logic             stable;
    logic             stable_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // Any sample matching the current level restarts the window, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the output.
    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        if (s2 != stable) begin
            if (cnt == CNT_MAX) begin
                stable_nxt = s2;
                rise_nxt   = s2;
                fall_nxt   = ~s2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable  <= 1'b0;
            cnt     <= '0;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            stable  <= stable_nxt;
            cnt     <= cnt_nxt;
            sw_rise <= rise_nxt;
            sw_fall <= fall_nxt;
        end
    end

    assign sw_db = stable;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous slide-switch pins for the switch PIO in_port;
// every bit is filtered independently by its own debounce_bit.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .sw_raw (sw_raw[i]),
            .sw_db  (sw_db[i]),
            .sw_rise(sw_rise[i]),
            .sw_fall(sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: window-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_switch_debouncer;
    import switch_pkg::*;

    localparam int W = SW_WIDTH;
    localparam int D = SW_DEBOUNCE_CYCLES_SIM;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    int checks = 0;
    int errors = 0;

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall)
    );

    always #5 clk = ~clk;

    // Reference: hist holds the raw samples taken at past edges, newest first.
    // At an edge the filter sees the sample from two edges earlier; the level
    // flips when the D most recent filter-visible samples all disagree with it.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_db, m_rise, m_fall;
    logic [W-1:0] all1, all0, nxt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            hist   = {};
            for (int i = 0; i <= D; i++) hist.push_back('0);
        end else begin
            all1 = '1;
            all0 = '1;
            for (int i = 1; i <= D; i++) begin
                all1 = all1 & hist[i];
                all0 = all0 & ~hist[i];
            end
            nxt    = (m_db & ~all0) | (~m_db & all1);
            m_rise = nxt & ~m_db;
            m_fall = m_db & ~nxt;
            m_db   = nxt;
            hist.push_front(sw_raw);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        #1;
        checks++;
        if (sw_db !== m_db || sw_rise !== m_rise || sw_fall !== m_fall) begin
            errors++;
            $display("FAIL model t=%0t db=%h/%h rise=%h/%h fall=%h/%h (actual/required)",
                     $time, sw_db, m_db, sw_rise, m_rise, sw_fall, m_fall);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect3(input string name, input logic [W-1:0] db,
                           input logic [W-1:0] rise, input logic [W-1:0] fall);
        checks++;
        if (sw_db !== db || sw_rise !== rise || sw_fall !== fall) begin
            errors++;
            $display("FAIL %s db=%h rise=%h fall=%h required db=%h rise=%h fall=%h",
                     name, sw_db, sw_rise, sw_fall, db, rise, fall);
        end
    endtask

    initial begin
        reset  = 1'b0;
        sw_raw = '0;
        #1 reset = 1'b1;

        // Reset with all switches high: outputs held at zero, then one rise.
        sw_raw = 10'h3FF;
        step(3);
        expect3("reset_hold", 10'h000, 10'h000, 10'h000);
        reset = 1'b0;
        step(5);
        expect3("reset_rel_pre", 10'h000, 10'h000, 10'h000);
        step(1);
        expect3("reset_rel_set", 10'h3FF, 10'h3FF, 10'h000);
        step(1);
        expect3("reset_rel_post", 10'h3FF, 10'h000, 10'h000);

        sw_raw = 10'h000;
        step(8);
        expect3("all_low", 10'h000, 10'h000, 10'h000);

        // Clean rising edge on bit 0.
        sw_raw = 10'h001;
        step(5);
        expect3("clean_pre", 10'h000, 10'h000, 10'h000);
        step(1);
        expect3("clean_set", 10'h001, 10'h001, 10'h000);
        step(1);
        expect3("clean_post", 10'h001, 10'h000, 10'h000);

        // Bounce on bit 3, then settle high.
        sw_raw = 10'h009; step(1);
        sw_raw = 10'h001; step(1);
        sw_raw = 10'h009; step(1);
        sw_raw = 10'h001; step(1);
        expect3("bounce_quiet", 10'h001, 10'h000, 10'h000);
        sw_raw = 10'h009;
        step(5);
        expect3("bounce_pre", 10'h001, 10'h000, 10'h000);
        step(1);
        expect3("bounce_set", 10'h009, 10'h008, 10'h000);
        step(1);
        expect3("bounce_post", 10'h009, 10'h000, 10'h000);

        // Three-cycle glitch on bit 5 never propagates.
        sw_raw = 10'h029;
        step(3);
        sw_raw = 10'h009;
        step(8);
        expect3("glitch", 10'h009, 10'h000, 10'h000);

        // Simultaneous fall on bit 0 and rise on bit 1.
        sw_raw = 10'h001;
        step(8);
        expect3("simul_base", 10'h001, 10'h000, 10'h000);
        sw_raw = 10'h002;
        step(5);
        expect3("simul_pre", 10'h001, 10'h000, 10'h000);
        step(1);
        expect3("simul_set", 10'h002, 10'h002, 10'h001);
        step(1);
        expect3("simul_post", 10'h002, 10'h000, 10'h000);

        // Reset while bit 7 is two counts into its window.
        sw_raw = 10'h080;
        step(4);
        reset = 1'b1;
        #1;
        expect3("midwin_reset", 10'h000, 10'h000, 10'h000);
        step(2);
        reset = 1'b0;
        step(5);
        expect3("midwin_pre", 10'h000, 10'h000, 10'h000);
        step(1);
        expect3("midwin_set", 10'h080, 10'h080, 10'h000);

        // Randomized soak against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] v;
            v = sw_raw;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            if ($urandom_range(0, 3) == 0) v = sw_raw;
            sw_raw = v;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            step(1);
        end
        reset = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the raw slide-switch inputs of the alarm-clock board before they reach the switch PIO's `in_port`. Each bit is synchronised into `clk` with a two-flop synchroniser, then filtered by a per-bit stability counter so that only levels held for `DEBOUNCE_CYCLES` consecutive clocks propagate. Single-cycle rise and fall strobes are also produced for fabric logic that needs edge events without polling the PIO.

## Interface
- `WIDTH`, default 10: number of switch bits; matches the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, default 500000: stability window in clocks (10 ms at 50 MHz). Legal range is 2 or more.
- `clk`, input, 1 bit: system clock, the same clock as the PIO.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `sw_raw`, input, `WIDTH` bits: asynchronous switch pins.
- `sw_db`, output, `WIDTH` bits: debounced level; drives the PIO `in_port`.
- `sw_rise`, output, `WIDTH` bits: one-cycle pulse when the matching `sw_db` bit goes 0→1.
- `sw_fall`, output, `WIDTH` bits: one-cycle pulse when the matching `sw_db` bit goes 1→0.

## Operation
- Each bit is fully independent. No cross-bit state exists.
- Synchroniser: `s1 <= sw_raw[i]`, then `s2 <= s1`. `s2` is the only raw value the filter uses.
- Filter state per bit:
  - `stable`: the current `sw_db` value.
  - `cnt`: width `$clog2(DEBOUNCE_CYCLES)`, unsigned.
- Per clock edge:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, and assert the strobe for the direction of the change.
  - Else: `cnt <= cnt + 1`.
- Any return of `s2` to `stable` before the window completes clears `cnt`, so glitches produce no output change.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- Strobes are registered. `sw_rise[i]` and `sw_fall[i]` are never high together. Each strobe is high for exactly the one cycle after `stable` changes.
- Reset asserted, or asserted mid-count: `s1`, `s2`, `stable`, `cnt`, `sw_db`, `sw_rise` and `sw_fall` all go to 0 immediately. Any in-progress window is discarded.
- After reset, a switch that is already high is reported only after a full window. This produces one `sw_rise` pulse, which is expected behaviour.

## Timing
- All outputs are registered. There is no combinational path from `sw_raw` to any output.
- Latency: if `sw_raw[i]` is first sampled with a new value at edge k and stays constant, `sw_db[i]` changes at edge k+1+`DEBOUNCE_CYCLES`. The strobe is high during the cycle that follows that edge.
- A level held for only `DEBOUNCE_CYCLES-1` `s2` cycles never reaches `sw_db`.
- The PIO adds one further register stage (its `readdata`). Software-visible latency is therefore the figure above plus one clock plus the bus read.
- Reset release: the first filter activity occurs on the first `clk` edge after `reset` deasserts. No reset synchroniser lives in this block; the system reset controller provides synchronous deassertion.

## Structure
- Sub-module `debounce_bit`: synchroniser, counter, `stable` and strobes for one bit, with `DEBOUNCE_CYCLES` as its parameter. `switch_debouncer` instantiates it `WIDTH` times in a generate loop.
- Shared package `switch_pkg`:
  - `SW_WIDTH = 10`.
  - `SW_DEBOUNCE_CYCLES_DEFAULT = 500000`.
  - `SW_DEBOUNCE_CYCLES_SIM = 4`, the bench value.
- Synthesis attributes mark `s1` and `s2` as synchroniser registers; the toolchain's standard metastability attribute is used.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `WIDTH=10`.
- Reset with `sw_raw=10'h3FF` held: during reset all outputs are 0. After release, `sw_db` becomes 3FF exactly 5 edges after the first post-reset sample, with a single `sw_rise=3FF` pulse and `sw_fall=0` throughout.
- Clean edge: `sw_raw[0]` goes 0→1 and is held. `sw_db[0]` rises at edge k+5 and `sw_rise[0]` is high for one cycle. The other bits stay unchanged.
- Bounce: `sw_raw[3]` toggles 1,0,1,0 at single-cycle intervals, then settles at 1. There is no output activity during the toggling. `sw_db[3]` rises 5 edges after the final settle, with exactly one `sw_rise[3]` pulse.
- Short glitch: `sw_raw[5]` is high for 3 cycles, then returns to 0. `sw_db[5]` stays 0 and no strobes occur.
- Simultaneous opposite events: `sw_db=10'h001`, then `sw_raw` is driven to `10'h002` in one cycle. After the window, `sw_db=002` and `sw_fall=001` and `sw_rise=002` pulse in the same cycle.
- Mid-window reset: `reset` is asserted when `cnt=2` on bit 7. All outputs clear immediately. After release with input still high, a full 5-edge window is required before `sw_db[7]` sets.
